serializador_piso: RTL and testbench
====================================

SERIALIZADOR_PISO -- requirements
Module: serializador_piso

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 SHALL have parameter DIV, default 4: clock cycles per serial bit period, legal range 1..256.
REQ-003 SHALL have port CLK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 SHALL have port RESET_N, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port DATA_IN, input, WIDTH bits: parallel word to serialize.
REQ-006 SHALL have port VALID_IN, input, 1 bit: DATA_IN holds a word.
REQ-007 SHALL have port READY_OUT, output, 1 bit: block can accept a word.
REQ-008 SHALL have port BIT_OUT, output, 1 bit: current serial bit, feeds downstream 1-bit register data input.
REQ-009 SHALL have port BIT_CE, output, 1 bit: one-cycle strobe per bit period, feeds downstream register clock enable.
REQ-010 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-011 SHALL have port DONE, output, 1 bit: one-cycle pulse on the last cycle of a word.

Function
REQ-012 SHALL implement states IDLE and SHIFT, plus PARITY when the feature is compiled in (REQ-024).
REQ-013 SHALL drive READY_OUT high only in IDLE; a word is accepted on a rising edge with VALID_IN and READY_OUT both high.
REQ-014 SHALL capture DATA_IN into an internal shift register on acceptance; later DATA_IN changes have no effect on that word.
REQ-015 SHALL transmit MSB first; bit k occupies cycles 1+k*DIV through (k+1)*DIV after the acceptance edge.
REQ-016 SHALL pulse BIT_CE high on the first cycle of each bit period only; with DIV=1, BIT_CE stays high for the whole SHIFT state.
REQ-017 SHALL hold BIT_OUT stable for the whole bit period, and SHALL hold it at 0 in IDLE.
REQ-018 SHALL assert DONE on the final cycle of the final bit period, then enter IDLE on the next edge.
REQ-019 SHALL leave exactly one IDLE cycle between back-to-back words when VALID_IN is held high.
REQ-020 SHALL ignore VALID_IN while BUSY is high; no word is dropped, because READY_OUT is low during that time.
REQ-021 SHALL size the bit-period and bit-index counters with $clog2 of their maximum value; counters SHALL never wrap within a word.

Reset
REQ-022 SHALL, while RESET_N is low, force state IDLE, READY_OUT=1 after release, and BIT_OUT=0, BIT_CE=0, BUSY=0, DONE=0, with counters and shift register cleared.
REQ-023 SHALL abort any word in progress when reset is asserted mid-operation, with no DONE pulse; the first edge after release SHALL already accept a new word.

Configuration
REQ-024 SHALL, with macro SERIALIZADOR_PARITY_EN defined, append one even-parity bit period (XOR of the captured word) after bit 0, with BIT_CE pulsed as for data bits; DONE then falls on the last parity cycle.
REQ-025 SHALL, without SERIALIZADOR_PARITY_EN, contain no PARITY state or parity logic, and frame length SHALL be exactly WIDTH*DIV cycles.

Structure
REQ-026 SHALL take the state enum and the default WIDTH/DIV constants from package serializador_pkg.
REQ-027 SHALL instantiate sub-module divisor_tick, which generates the bit-period start strobe and end-of-period flag from DIV, enabled only in SHIFT/PARITY.

Verification
REQ-028 SHALL cover: WIDTH=8, DIV=4, word 0xA5 accepted at cycle 0 -> BIT_CE at cycles 1,5,...,29; BIT_OUT 1,0,1,0,0,1,0,1; DONE at cycle 32; READY_OUT high at cycle 33.
REQ-029 SHALL cover: VALID_IN held high with words 0x3C then 0xC3 -> second word accepted at cycle 33, first BIT_CE of second word at cycle 34.
REQ-030 SHALL cover: RESET_N pulsed low at cycle 10 of word 0xFF -> all outputs 0 immediately, no DONE pulse, word 0x01 accepted on the first edge after release.
REQ-031 SHALL cover: DIV=1, word 0x81 -> BIT_CE continuously high for cycles 1..8, BIT_OUT 1,0,0,0,0,0,0,1, DONE at cycle 8.
REQ-032 SHALL cover, with SERIALIZADOR_PARITY_EN: 0xA5 gives parity bit 0 in cycles 33..36 with DONE at 36, and 0xA4 gives parity bit 1.
REQ-033 SHALL cover: DATA_IN changed to 0x00 at cycle 2 of word 0xA5 -> serial output unchanged from REQ-028.

Source files
------------

// File: rtl/serializador_pkg.sv
// rtl/serializador_pkg.sv - shared constants and state encoding for the PISO serializer
// Optional feature macro: SERIALIZADOR_PARITY_EN (adds the PARITY state).
package serializador_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DIV   = 4;

`ifdef SERIALIZADOR_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;
`endif

endpackage

// File: rtl/serializador_piso_if.sv
// rtl/serializador_piso_if.sv - word handshake and serial output bundle of the PISO serializer
// Signals:
//   DATA_IN / VALID_IN          producer -> serializer (parallel word offer)
//   READY_OUT                   serializer -> producer (word accepted when VALID_IN & READY_OUT)
//   BIT_OUT / BIT_CE            serial data and per-bit-period clock enable for the downstream register
//   BUSY / DONE                 status: not idle / last cycle of the frame
// Modports: master = word producer side, slave = serializer side.
interface serializador_piso_if
  import serializador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] DATA_IN;
  logic             VALID_IN;
  logic             READY_OUT;
  logic             BIT_OUT;
  logic             BIT_CE;
  logic             BUSY;
  logic             DONE;

  modport master (
    output DATA_IN, VALID_IN,
    input  READY_OUT, BIT_OUT, BIT_CE, BUSY, DONE
  );

  modport slave (
    input  DATA_IN, VALID_IN,
    output READY_OUT, BIT_OUT, BIT_CE, BUSY, DONE
  );

endinterface

// File: rtl/serializador_piso_divisor_tick.sv
// rtl/serializador_piso_divisor_tick.sv - bit-period divider: start strobe and end-of-period flag
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en_i         count while high; held at period start while low
//   tick_o       high on the first cycle of each period
//   last_o       high on the last cycle of each period (same cycle as tick_o when DIV=1)
module divisor_tick
  import serializador_pkg::*;
#(
  parameter int DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o,
  output logic last_o
);

  // Counter only needs to reach DIV-1; keep at least one bit for DIV=1.
  localparam int            CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == CNT_MAX) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);
  assign last_o = en_i && (cnt_q == CNT_MAX);

endmodule

// File: rtl/serializador_piso.sv
// rtl/serializador_piso.sv - parallel-in serial-out serializer, MSB first, DIV clocks per bit
// Ports:
//   CLK      clock, rising edge
//   RESET_N  asynchronous active-low reset; aborts any frame in progress
//   bus      serializador_piso_if.slave: DATA_IN/VALID_IN/READY_OUT word handshake,
//            BIT_OUT/BIT_CE serial output, BUSY/DONE status
// Optional feature macro: SERIALIZADOR_PARITY_EN appends one even-parity bit period.
module serializador_piso
  import serializador_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic                CLK,
  input  logic                RESET_N,
  serializador_piso_if.slave  bus
);

  localparam int            IW       = $clog2(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [IW-1:0]    idx_q;
  logic             active;
  logic             tick;
  logic             period_end;
  logic             final_period;

`ifdef SERIALIZADOR_PARITY_EN
  logic             par_q;
`endif

  assign active = (state_q != ST_IDLE);

  divisor_tick #(
    .DIV (DIV)
  ) u_divisor_tick (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .en_i   (active),
    .tick_o (tick),
    .last_o (period_end)
  );

  // The serial bit is always the shift register MSB; clearing the register
  // on frame end is what keeps BIT_OUT low in IDLE.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.VALID_IN) begin
            state_q <= ST_SHIFT;
            shreg_q <= bus.DATA_IN;
            idx_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
            par_q   <= ^bus.DATA_IN;
`endif
          end
        end
        ST_SHIFT: begin
          if (period_end) begin
            if (idx_q == IDX_LAST) begin
              idx_q   <= '0;
`ifdef SERIALIZADOR_PARITY_EN
              state_q <= ST_PARITY;
              shreg_q <= {par_q, {(WIDTH - 1){1'b0}}};
`else
              state_q <= ST_IDLE;
              shreg_q <= '0;
`endif
            end else begin
              idx_q   <= idx_q + 1'b1;
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end
          end
        end
`ifdef SERIALIZADOR_PARITY_EN
        ST_PARITY: begin
          if (period_end) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SERIALIZADOR_PARITY_EN
  assign final_period = (state_q == ST_PARITY);
`else
  assign final_period = (state_q == ST_SHIFT) && (idx_q == IDX_LAST);
`endif

  // READY_OUT is gated by RESET_N so every output reads 0 while reset is held,
  // yet is high immediately after release so the first edge can accept.
  assign bus.READY_OUT = RESET_N && (state_q == ST_IDLE);
  assign bus.BUSY      = active;
  assign bus.BIT_CE    = tick;
  assign bus.BIT_OUT   = shreg_q[WIDTH-1];
  assign bus.DONE      = period_end && final_period;

endmodule

// File: tb/tb_serializador_piso.sv
// tb/tb_serializador_piso.sv - self-checking bench for serializador_piso (DIV=4 and DIV=1 instances)
module tb_serializador_piso;
  import serializador_pkg::*;

  localparam int W = 8;
`ifdef SERIALIZADOR_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  serializador_piso_if #(.WIDTH(W)) ia ();
  serializador_piso_if #(.WIDTH(W)) ib ();

  serializador_piso #(.WIDTH(W), .DIV(4)) dut_a (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (ia.slave)
  );

  serializador_piso #(.WIDTH(W), .DIV(1)) dut_b (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (ib.slave)
  );

  // Expected {READY, BUSY, BIT_CE, BIT_OUT, DONE} for cycle c after the acceptance edge.
  function automatic logic [4:0] model(input logic [W-1:0] w, input int div, input int c);
    int len;
    int k;
    logic [4:0] r;
    len = (W + PB) * div;
    if (c < 1 || c > len) begin
      r = 5'b10000;
    end else begin
      k = (c - 1) / div;
      r[4] = 1'b0;
      r[3] = 1'b1;
      r[2] = ((c - 1) % div) == 0;
      r[1] = (k < W) ? w[W-1-k] : ^w;
      r[0] = (c == len);
    end
    return r;
  endfunction

  function automatic logic [4:0] observe(input bit sel);
    if (sel) return {ib.READY_OUT, ib.BUSY, ib.BIT_CE, ib.BIT_OUT, ib.DONE};
    return {ia.READY_OUT, ia.BUSY, ia.BIT_CE, ia.BIT_OUT, ia.DONE};
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed rdy/bsy/ce/bit/done=%b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_data(input bit sel, input logic [W-1:0] d);
    if (sel) ib.DATA_IN = d;
    else ia.DATA_IN = d;
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) ib.VALID_IN = v;
    else ia.VALID_IN = v;
  endtask

  // Checks cycles 1..stop_at (0: whole frame plus the idle cycle after it).
  // mode 1 zeroes DATA_IN at cycle 2, mode 2 scrambles it every frame cycle.
  task automatic run_frame(input bit sel, input logic [W-1:0] w, input int stop_at, input int mode);
    int div;
    int len;
    int last;
    div  = sel ? 1 : 4;
    len  = (W + PB) * div;
    last = (stop_at > 0) ? stop_at : len + 1;
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      check($sformatf("%s w=%02h c=%0d", sel ? "div1" : "div4", w, c), observe(sel), model(w, div, c));
      if (mode == 1 && c == 2) set_data(sel, '0);
      if (mode == 2 && c <= len) set_data(sel, W'($urandom));
    end
  endtask

  // Offer a word (VALID held through the frame) and check the full frame.
  task automatic send(input bit sel, input logic [W-1:0] w, input int mode);
    set_data(sel, w);
    set_valid(sel, 1'b1);
    @(posedge CLK);
    run_frame(sel, w, 0, mode);
    set_valid(sel, 1'b0);
  endtask

  task automatic idle_gap(input bit sel);
    @(negedge CLK);
    check($sformatf("gap %s", sel ? "div1" : "div4"), observe(sel), 5'b10000);
  endtask

  initial begin
    logic [W-1:0] rw;
    bit           rs;

    ia.DATA_IN = '0; ia.VALID_IN = 1'b0;
    ib.DATA_IN = '0; ib.VALID_IN = 1'b0;

    repeat (2) @(negedge CLK);
    check("reset div4", observe(0), 5'b00000);
    check("reset div1", observe(1), 5'b00000);
    RESET_N = 1'b1;
    #1;
    check("release div4", observe(0), 5'b10000);
    check("release div1", observe(1), 5'b10000);

    send(0, 8'hA5, 0);
    idle_gap(0);
    send(0, 8'hA5, 1);
    idle_gap(0);
    send(0, 8'hA4, 0);
    idle_gap(0);

    send(0, 8'h3C, 0);
    send(0, 8'hC3, 0);
    idle_gap(0);

    set_data(0, 8'hFF);
    set_valid(0, 1'b1);
    @(posedge CLK);
    run_frame(0, 8'hFF, 9, 0);
    @(negedge CLK);
    RESET_N = 1'b0;
    set_valid(0, 1'b0);
    #1;
    check("abort div4", observe(0), 5'b00000);
    check("abort div1", observe(1), 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check($sformatf("held reset %0d", i), observe(0), 5'b00000);
    end
    RESET_N = 1'b1;
    #1;
    check("post-abort ready", observe(0), 5'b10000);
    send(0, 8'h01, 0);
    idle_gap(0);

    send(1, 8'h81, 0);
    idle_gap(1);

    for (int i = 0; i < 6; i++) begin
      rw = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      send(rs, rw, 2);
      idle_gap(rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
